// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: m0 has fixed priority,
// m1 is guaranteed a slot after MAX_HOLD consecutive m0 wins.
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD} state_t;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t            state, state_next;
    logic [3:0]        hold_cnt;
    logic [2:0]        lat_cnt;
    logic              lat_m1;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req;
    logic              pick_m1;
    logic              rd_done;

    assign any_req = m0_req | m1_req;
    // m1 wins when alone, or when m0 has used up its consecutive-grant allowance.
    assign pick_m1 = m1_req & (~m0_req | (hold_cnt >= HOLD_MAX));
    assign rd_done = (state == WAIT_RD) && (lat_cnt == 3'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = ACCESS;
            end
            ACCESS: begin
                m0_gnt     = ~lat_m1;
                m1_gnt     = lat_m1;
                mem_we     = lat_we;
                mem_re     = ~lat_we;
                state_next = lat_we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (rd_done) begin
                    m0_rvalid  = ~lat_m1;
                    m1_rvalid  = lat_m1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            lat_cnt   <= '0;
            lat_m1    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        lat_m1    <= pick_m1;
                        lat_we    <= pick_m1 ? m1_we    : m0_we;
                        lat_addr  <= pick_m1 ? m1_addr  : m0_addr;
                        lat_wdata <= pick_m1 ? m1_wdata : m0_wdata;
                    end
                    if (!m1_req || pick_m1)   hold_cnt <= '0;
                    else if (hold_cnt != 4'hF) hold_cnt <= hold_cnt + 4'd1;
                end
                ACCESS: begin
                    if (!lat_we) lat_cnt <= LAT_INIT;
                end
                WAIT_RD: begin
                    if (lat_cnt != 3'd0) lat_cnt <= lat_cnt - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Address and write data come straight from the latch, so they hold between commands.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each with a small behavioural memory.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Instance A: RD_LAT=1
    logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_rvalid;
    logic [15:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
    logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_rvalid;
    logic [15:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
    logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_we, a_mem_re, a_busy;

    // Instance B: RD_LAT=3
    logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid;
    logic [15:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
    logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid;
    logic [15:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_we, b_mem_re, b_busy;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .MAX_HOLD(4)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_re(a_mem_re), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3), .MAX_HOLD(4)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_re(b_mem_re), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models; 0xDEAD marks cycles where read data is not meaningful.
    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] pipe_b [0:2];

    always @(posedge clk) begin
        if (reset)         mem_a[8'h10] <= 16'hBEEF;
        else if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
        a_mem_rdata <= a_mem_re ? mem_a[a_mem_addr[7:0]] : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (reset)         mem_b[8'h20] <= 16'hCAFE;
        else if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        pipe_b[0] <= b_mem_re ? mem_b[b_mem_addr[7:0]] : 16'hDEAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_mem_rdata = pipe_b[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int who;
        reset = 1'b1;
        {a_m0_req, a_m0_we, a_m1_req, a_m1_we} = '0;
        {a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata} = '0;
        {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
        {b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata} = '0;
        repeat (3) tick();

        // Reset state
        check("rst_a_strobes", {a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we, a_mem_re, a_busy}, 0);
        check("rst_a_data", {a_m0_rdata, a_m1_rdata}, 0);
        check("rst_a_mem", {a_mem_addr, a_mem_wdata}, 0);
        check("rst_b_strobes", {b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_mem_re, b_busy}, 0);

        // Test 1: m0 read of 0x0010, RD_LAT=1
        reset = 1'b0;
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 16'h0010;
        tick();
        check("t1_gnt", {a_m0_gnt, a_m1_gnt, a_mem_re, a_mem_we, a_busy}, 5'b10101);
        check("t1_addr", a_mem_addr, 16'h0010);
        check("t1_rdata_gate", a_m0_rdata, 0);
        a_m0_req = 1'b0;
        tick();
        check("t1_rvalid", {a_m0_rvalid, a_m1_rvalid, a_m0_gnt, a_mem_re, a_busy}, 5'b10001);
        check("t1_rdata", a_m0_rdata, 16'hBEEF);
        tick();
        check("t1_idle", {a_m0_rvalid, a_busy, a_m0_rdata}, 0);

        // Test 2: m1 write 0x1234 to 0x0004, then read it back
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 16'h0004; a_m1_wdata = 16'h1234;
        tick();
        check("t2_wr_gnt", {a_m1_gnt, a_m0_gnt, a_mem_we, a_mem_re}, 4'b1010);
        check("t2_wr_bus", {a_mem_addr, a_mem_wdata}, {16'h0004, 16'h1234});
        a_m1_req = 1'b0;
        tick();
        check("t2_busy_drop", {a_busy, a_mem_we}, 0);
        a_m1_req = 1'b1; a_m1_we = 1'b0;
        tick();
        check("t2_rd_gnt", {a_m1_gnt, a_mem_re}, 2'b11);
        a_m1_req = 1'b0;
        tick();
        check("t2_rd_data", {a_m1_rvalid, a_m0_rvalid, a_m1_rdata}, {2'b10, 16'h1234});
        tick();

        // Test 3: both requesters writing continuously, MAX_HOLD=4
        a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 16'h0040; a_m0_wdata = 16'h0F0F;
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 16'h0050; a_m1_wdata = 16'hF0F0;
        for (int g = 0; g < 10; g++) begin
            who = -1;
            for (int c = 0; c < 4 && who < 0; c++) begin
                tick();
                if (a_m0_gnt && a_m1_gnt) who = 2;
                else if (a_m0_gnt)        who = 0;
                else if (a_m1_gnt)        who = 1;
            end
            check($sformatf("t3_order[%0d]", g), who, (g % 5 == 4) ? 1 : 0);
        end
        a_m0_req = 1'b0; a_m1_req = 1'b0;
        tick();
        tick();

        // Test 6: back-to-back m0 writes to 0x0000..0x0003 with m1 idle
        a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 16'h0000; a_m0_wdata = 16'hA000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6_gnt[%0d]", i), {a_m0_gnt, a_mem_we}, 2'b11);
            a_m0_addr  = 16'(i + 1);
            a_m0_wdata = 16'hA000 + 16'(i + 1);
            if (i == 3) a_m0_req = 1'b0;
            tick();
            check($sformatf("t6_gap[%0d]", i), {a_m0_gnt, a_busy}, 0);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("t6_mem[%0d]", i), mem_a[i], 16'hA000 + 16'(i));
        check("t6_hold_cnt", dut_a.hold_cnt, 0);

        // Test 4: RD_LAT=3 m0 read, m1 write raised during WAIT_RD
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 16'h0020;
        tick();
        check("t4_m0_gnt", {b_m0_gnt, b_mem_re}, 2'b11);
        b_m0_req = 1'b0;
        tick();
        b_m1_req = 1'b1; b_m1_we = 1'b1; b_m1_addr = 16'h0030; b_m1_wdata = 16'h5555;
        check("t4_wait1", {b_mem_re, b_mem_we, b_m1_gnt, b_m0_rvalid, b_busy}, 5'b00001);
        tick();
        check("t4_wait2", {b_mem_re, b_mem_we, b_m1_gnt, b_m0_rvalid, b_busy}, 5'b00001);
        tick();
        check("t4_rvalid", {b_m0_rvalid, b_m1_gnt, b_mem_re, b_mem_we}, 4'b1000);
        check("t4_rdata", b_m0_rdata, 16'hCAFE);
        tick();
        check("t4_idle", {b_busy, b_m1_gnt, b_m0_rvalid}, 0);
        tick();
        check("t4_m1_gnt", {b_m1_gnt, b_mem_we, b_mem_re}, 3'b110);
        check("t4_m1_bus", {b_mem_addr, b_mem_wdata}, {16'h0030, 16'h5555});
        b_m1_req = 1'b0;
        tick();

        // Test 5: reset in the cycle after an m1 read grant
        b_m1_req = 1'b1; b_m1_we = 1'b0; b_m1_addr = 16'h0020;
        tick();
        check("t5_gnt", {b_m1_gnt, b_mem_re}, 2'b11);
        b_m1_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("t5_rst_strobes", {b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_mem_re, b_busy}, 0);
        check("t5_rst_data", {b_m1_rdata, b_mem_addr, b_mem_wdata}, 0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("t5_no_rvalid[%0d]", c), {b_m1_rvalid, b_busy}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
